window_buffer_kxk_stream: RTL and testbench
===========================================

WINDOW_BUFFER_KXK_STREAM -- requirements
Module: window_buffer_kxk_stream

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning pixel width in bits (signed Q8.8 at default).
REQ-002 The module SHALL have parameter K, default 3, meaning window size; legal values are 3 and 5.
REQ-003 The module SHALL have parameter MAX_WIDTH, default 256, meaning line-buffer depth in pixels.
REQ-004 The module SHALL have parameter DIM_W, default 8, meaning bit width of the image dimensions.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit: one-cycle pulse that latches the configuration and begins a frame.
REQ-008 The module SHALL have ports img_width and img_height, input, DIM_W bits each: frame dimensions.
REQ-009 The module SHALL have port padding_mode, input, 2 bits: 00 = no padding (window top-left at position), 01 = zero padding (window centred, border = 0).
REQ-010 The module SHALL have port stride, input, 2 bits: 01 = stride 1, 10 = stride 2.
REQ-011 The module SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_ready (output, 1): raster-order pixel stream.
REQ-012 The module SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_window (output, K*K*DATA_W): element (i,j) occupies bits [(i*K+j)*DATA_W +: DATA_W], with i = 0 the top row.
REQ-013 The module SHALL have ports out_last (output, 1), busy (output, 1) and cfg_err (output, 1): last window of frame, frame in progress, and one-cycle configuration-error pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DRAIN: start moves IDLE->RUN; the final input pixel moves RUN->DRAIN; the final output handshake moves DRAIN (or RUN) ->IDLE.
REQ-015 In states other than IDLE, start SHALL be ignored.
REQ-016 On start, if img_width or img_height is 0, img_width > MAX_WIDTH, padding_mode is 1x, stride is 00/11, or (no padding and width or height < K), the block SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-017 The configuration SHALL be latched at start; input changes during a frame SHALL have no effect.
REQ-018 An input pixel SHALL be accepted when in_valid && in_ready.
REQ-019 Input pixels SHALL be written to K circular line buffers indexed by input_row mod K at input_col.
REQ-020 Windows SHALL be emitted in row-major order over output positions.
REQ-021 In zero-padding mode, output positions SHALL be rows 0..H-1 and columns 0..W-1 stepping by stride, with out-of-image taps = 0.
REQ-022 In no-padding mode, output positions SHALL be rows 0..H-K and columns 0..W-K stepping by stride.
REQ-023 A window SHALL be presented only after every in-image pixel it covers has been accepted.
REQ-024 out_valid SHALL assert no earlier than 1 cycle after the window's last needed pixel is accepted.
REQ-025 out_window, out_valid and out_last SHALL be registered and SHALL remain stable while out_valid && !out_ready.
REQ-026 in_ready SHALL be 0 in IDLE, in DRAIN, and whenever accepting the next pixel would overwrite a row still needed by the oldest un-emitted window; otherwise it SHALL be 1.
REQ-027 At stride 1 with out_ready held high, throughput SHALL be one window per cycle.
REQ-028 out_last SHALL be 1 exactly with the final window of the frame.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 Counters SHALL wrap: input_col returns to 0 at W-1 and increments the row.
REQ-031 A window whose bottom-right tap is accepted in the same cycle SHALL use the bypassed in_data value.

Reset
REQ-032 On rst_n low, at any time including mid-frame, the FSM SHALL go to IDLE; out_valid, out_last, in_ready, busy and cfg_err SHALL be 0, out_window SHALL be 0, and all counters SHALL be 0.
REQ-033 Line-buffer contents SHALL NOT be reset; stale data SHALL never be emitted.

Configuration
REQ-034 With macro WINDOW_BUF_STRIDE2_EN defined, stride 10 SHALL be supported per REQ-021/022.
REQ-035 Without WINDOW_BUF_STRIDE2_EN, stride logic SHALL be omitted, stride 10 SHALL raise cfg_err, and only stride 1 SHALL be legal.

Verification
REQ-036 K=3, 4x4 ramp 0..15, zero padding, stride 1, out_ready=1 -> 16 windows; first = {0,0,0, 0,0,1, 0,4,5}; last = {10,11,0, 14,15,0, 0,0,0} with out_last=1.
REQ-037 K=3, 4x4 ramp, no padding -> 4 windows; first = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}.
REQ-038 Stride 2 (macro defined), 5x5 ramp, no padding -> 4 windows with top-left pixels 0, 2, 10, 12.
REQ-039 Backpressure: out_ready held low 20 cycles mid-frame -> out_window stable, in_ready drops to 0, and no window is lost or duplicated after release.
REQ-040 rst_n pulsed after 7 pixels, then a new start on a 4x4 frame -> first window matches REQ-036 exactly; start with img_width=2 in no-padding mode -> cfg_err=1 for one cycle and busy stays 0.

Source files
------------

// File: rtl/window_buffer_kxk_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : window_buffer_kxk_stream_if
//  Purpose  : Bundles the raster pixel input stream and the KxK window output
//             stream of window_buffer_kxk_stream.
//  Signals  : in_valid / in_data / in_ready          - pixel stream
//             out_valid / out_ready / out_window /
//             out_last                               - window stream
//  Modports : slave  - the window buffer (consumes pixels, produces windows)
//             master - the environment (produces pixels, consumes windows)
//  Revision : 1.0  initial release
// ============================================================================
interface window_buffer_kxk_stream_if #(
    parameter int DATA_W = 16,
    parameter int K      = 3
);
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [K*K*DATA_W-1:0]   out_window;
    logic                    out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_window, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_window, out_last
    );
endinterface
`default_nettype wire

// File: rtl/window_buffer_kxk_stream.sv
`default_nettype none
// ============================================================================
//  Module   : window_buffer_kxk_stream
//  Purpose  : Streaming KxK sliding-window generator. Raster pixels are
//             written into K circular line buffers; windows are emitted in
//             row-major order over the output positions, either centred with
//             zero padding or top-left anchored without padding.
//  Ports    : clk, rst_n (async, active low)
//             start        - one-cycle pulse, latches the configuration
//             img_width, img_height, padding_mode, stride - frame config
//             bus (slave)  - pixel input stream and window output stream
//             busy         - frame in progress
//             cfg_err      - one-cycle pulse on an illegal configuration
//  Options  : WINDOW_BUF_STRIDE2_EN - when defined, stride 2'b10 is legal
//             and the output position steps by 2; otherwise only stride 1.
//  Revision : 1.0  initial release
// ============================================================================
module window_buffer_kxk_stream #(
    parameter int DATA_W    = 16,
    parameter int K         = 3,
    parameter int MAX_WIDTH = 256,
    parameter int DIM_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIM_W-1:0]           img_width,
    input  logic [DIM_W-1:0]           img_height,
    input  logic [1:0]                 padding_mode,
    input  logic [1:0]                 stride,
    window_buffer_kxk_stream_if.slave  bus,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int SW   = $clog2(K);
    localparam int HALF = (K - 1) / 2;
    localparam int NTAP = K * K;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // latched configuration
    logic [DIM_W-1:0]        r_width;
    logic [DIM_W-1:0]        r_height;
    logic                    r_pad;
`ifdef WINDOW_BUF_STRIDE2_EN
    logic                    r_stride2;
`endif

    // input position (next pixel to accept) and its line-buffer slot
    logic [DIM_W-1:0]        r_in_row;
    logic [DIM_W-1:0]        r_in_col;
    logic [SW-1:0]           r_in_slot;
    logic                    r_in_done;

    // output position of the oldest window not yet captured
    logic [DIM_W-1:0]        r_out_row;
    logic [DIM_W-1:0]        r_out_col;
    logic                    r_out_done;

    logic                    r_out_valid;
    logic                    r_out_last;
    logic [NTAP*DATA_W-1:0]  r_out_window;
    logic                    r_cfg_err;

    logic [DATA_W-1:0]       r_lb [K][MAX_WIDTH];

    logic                    w_cfg_bad;
    logic                    w_start_ok;
    logic                    w_in_ready;
    logic                    w_in_acc;
    logic                    w_in_final;
    logic                    w_avail;
    logic                    w_load;
    logic                    w_col_wrap;
    logic                    w_row_wrap;
    logic                    w_last_hs;
    int                      w_off;
    int                      w_step;
    int                      w_tr;
    int                      w_tc;
    int                      w_need_row;
    int                      w_br_row;
    int                      w_br_col;
    int                      w_last_row;
    int                      w_last_col;
    logic [NTAP*DATA_W-1:0]  w_window;

    // ------------------------------------------------------------------
    // Configuration legality, evaluated on the raw inputs at start
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_bad = 1'b0;
        if (img_width == '0 || img_height == '0)
            w_cfg_bad = 1'b1;
        if (int'(img_width) > MAX_WIDTH)
            w_cfg_bad = 1'b1;
        if (padding_mode[1])
            w_cfg_bad = 1'b1;
`ifdef WINDOW_BUF_STRIDE2_EN
        if (stride != 2'b01 && stride != 2'b10)
            w_cfg_bad = 1'b1;
`else
        if (stride != 2'b01)
            w_cfg_bad = 1'b1;
`endif
        if (padding_mode == 2'b00 && (int'(img_width) < K || int'(img_height) < K))
            w_cfg_bad = 1'b1;
    end

    assign w_start_ok = start && (r_state == S_IDLE) && !w_cfg_bad;

    // ------------------------------------------------------------------
    // Window geometry for the current output position
    // ------------------------------------------------------------------
    always_comb begin
        w_off = r_pad ? HALF : 0;
`ifdef WINDOW_BUF_STRIDE2_EN
        w_step = r_stride2 ? 2 : 1;
`else
        w_step = 1;
`endif
        // top-left tap of the window (negative rows/cols lie in the padding)
        w_tr = int'(r_out_row) - w_off;
        w_tc = int'(r_out_col) - w_off;
        w_need_row = (w_tr < 0) ? 0 : w_tr;
        // last in-image pixel the window depends on
        w_br_row = w_tr + K - 1;
        if (w_br_row > int'(r_height) - 1)
            w_br_row = int'(r_height) - 1;
        w_br_col = w_tc + K - 1;
        if (w_br_col > int'(r_width) - 1)
            w_br_col = int'(r_width) - 1;
        w_last_row = r_pad ? int'(r_height) - 1 : int'(r_height) - K;
        w_last_col = r_pad ? int'(r_width) - 1  : int'(r_width) - K;
        w_col_wrap = (int'(r_out_col) + w_step) > w_last_col;
        w_row_wrap = (int'(r_out_row) + w_step) > w_last_row;
    end

    // Accepting row R overwrites row R-K in the same slot; that is only safe
    // once R-K lies above the oldest window still to be captured.
    assign w_in_ready = (r_state == S_RUN) &&
                        (r_out_done || (int'(r_in_row) < w_need_row + K));
    assign w_in_acc   = bus.in_valid && w_in_ready;
    assign w_in_final = (int'(r_in_row) == int'(r_height) - 1) &&
                        (int'(r_in_col) == int'(r_width) - 1);

    // Window is ready once its last in-image pixel has been accepted, or is
    // being accepted right now (that tap then comes from in_data).
    always_comb begin
        w_avail = 1'b0;
        if (r_state != S_IDLE && !r_out_done) begin
            if (r_in_done || int'(r_in_row) > w_br_row ||
                (int'(r_in_row) == w_br_row && int'(r_in_col) > w_br_col))
                w_avail = 1'b1;
            if (w_in_acc && int'(r_in_row) == w_br_row && int'(r_in_col) == w_br_col)
                w_avail = 1'b1;
        end
    end

    assign w_load = w_avail && (!r_out_valid || bus.out_ready);

    // ------------------------------------------------------------------
    // Tap gather: zero outside the image, bypass for the pixel in flight
    // ------------------------------------------------------------------
    always_comb begin
        w_window = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin : tap_blk
                automatic int row = w_tr + i;
                automatic int col = w_tc + j;
                if (row >= 0 && row < int'(r_height) && col >= 0 && col < int'(r_width)) begin
                    if (w_in_acc && row == int'(r_in_row) && col == int'(r_in_col))
                        w_window[(i*K+j)*DATA_W +: DATA_W] = bus.in_data;
                    else
                        w_window[(i*K+j)*DATA_W +: DATA_W] = r_lb[SW'(row % K)][AW'(col)];
                end
            end
        end
    end

    // Line buffers carry no reset; every emitted tap is gated by position.
    always_ff @(posedge clk) begin
        if (w_in_acc)
            r_lb[r_in_slot][AW'(r_in_col)] <= bus.in_data;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_hs   = r_out_valid && r_out_last && bus.out_ready;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_last_hs)
                    w_state_nxt = S_IDLE;
                else if (w_in_acc && w_in_final)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration, counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width      <= '0;
            r_height     <= '0;
            r_pad        <= 1'b0;
`ifdef WINDOW_BUF_STRIDE2_EN
            r_stride2    <= 1'b0;
`endif
            r_in_row     <= '0;
            r_in_col     <= '0;
            r_in_slot    <= '0;
            r_in_done    <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_out_done   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_window <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= start && (r_state == S_IDLE) && w_cfg_bad;

            if (w_start_ok) begin
                r_width    <= img_width;
                r_height   <= img_height;
                r_pad      <= (padding_mode == 2'b01);
`ifdef WINDOW_BUF_STRIDE2_EN
                r_stride2  <= (stride == 2'b10);
`endif
                r_in_row   <= '0;
                r_in_col   <= '0;
                r_in_slot  <= '0;
                r_in_done  <= 1'b0;
                r_out_row  <= '0;
                r_out_col  <= '0;
                r_out_done <= 1'b0;
            end else begin
                if (w_in_acc) begin
                    if (w_in_final) begin
                        r_in_done <= 1'b1;
                    end else if (int'(r_in_col) == int'(r_width) - 1) begin
                        r_in_col  <= '0;
                        r_in_row  <= DIM_W'(int'(r_in_row) + 1);
                        r_in_slot <= (int'(r_in_slot) == K - 1) ? '0 : SW'(int'(r_in_slot) + 1);
                    end else begin
                        r_in_col  <= DIM_W'(int'(r_in_col) + 1);
                    end
                end
                if (w_load) begin
                    if (w_col_wrap) begin
                        r_out_col <= '0;
                        if (w_row_wrap)
                            r_out_done <= 1'b1;
                        else
                            r_out_row <= DIM_W'(int'(r_out_row) + w_step);
                    end else begin
                        r_out_col <= DIM_W'(int'(r_out_col) + w_step);
                    end
                end
            end

            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_window <= w_window;
                r_out_last   <= w_col_wrap && w_row_wrap;
            end else if (bus.out_ready) begin
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_window = r_out_window;
    assign bus.out_last   = r_out_last;
    assign busy           = (r_state != S_IDLE);
    assign cfg_err        = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_window_buffer_kxk_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_buffer_kxk_stream
//  Purpose  : Directed self-checking bench for window_buffer_kxk_stream
//             (K=3, 16-bit pixels, ramp images).
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_buffer_kxk_stream;

    localparam int DATA_W    = 16;
    localparam int K         = 3;
    localparam int MAX_WIDTH = 256;
    localparam int DIM_W     = 8;
    localparam int WW        = K * K * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  img_width = '0;
    logic [DIM_W-1:0]  img_height = '0;
    logic [1:0]        padding_mode = 2'b00;
    logic [1:0]        stride = 2'b01;
    logic              busy;
    logic              cfg_err;

    always #5 clk = ~clk;

    window_buffer_kxk_stream_if #(.DATA_W(DATA_W), .K(K)) bus ();

    window_buffer_kxk_stream #(
        .DATA_W    (DATA_W),
        .K         (K),
        .MAX_WIDTH (MAX_WIDTH),
        .DIM_W     (DIM_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .img_width    (img_width),
        .img_height   (img_height),
        .padding_mode (padding_mode),
        .stride       (stride),
        .bus          (bus.slave),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WW-1:0]    got_win[$];
    logic             got_last[$];
    logic [WW-1:0]    exp_q[$];
    bit               done_flag;
    bit               saw_block;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] pk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int a[9];
        logic [WW-1:0] v;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        v = '0;
        for (int k = 0; k < 9; k++)
            v[k*DATA_W +: DATA_W] = DATA_W'(a[k]);
        return v;
    endfunction

    // Reference window of a ramp image (pixel = row*w + col) at output (r,c)
    function automatic logic [WW-1:0] model_win(input int w, h, pad, r, c);
        logic [WW-1:0] v;
        int off, rr, cc;
        v = '0;
        off = pad ? (K - 1) / 2 : 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                rr = r - off + i;
                cc = c - off + j;
                if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                    v[(i*K+j)*DATA_W +: DATA_W] = DATA_W'(rr * w + cc);
            end
        return v;
    endfunction

    task automatic run_frame(input int w, h, pad, str, stall_at, stall_len, input string tag);
        int lr, lc, step, n, nlast;
        bit timeout;
        step = (str == 2) ? 2 : 1;
        lr = pad ? h - 1 : h - K;
        lc = pad ? w - 1 : w - K;
        exp_q.delete();
        for (int r = 0; r <= lr; r += step)
            for (int c = 0; c <= lc; c += step)
                exp_q.push_back(model_win(w, h, pad, r, c));
        got_win.delete();
        got_last.delete();
        saw_block = 0;
        done_flag = 0;
        timeout   = 1;
        n         = 0;

        @(posedge clk); #1;
        img_width = DIM_W'(w); img_height = DIM_W'(h);
        padding_mode = 2'(pad); stride = 2'(str); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // configuration is latched; later changes must not matter
        img_width = 8'd1; img_height = 8'd1; padding_mode = 2'b11; stride = 2'b00;

        fork
            begin
                bit acc;
                for (int p = 0; p < w * h && !done_flag; p++) begin
                    acc = 0;
                    bus.in_valid = 1'b1;
                    bus.in_data  = DATA_W'(p);
                    for (int t = 0; t < 400 && !acc && !done_flag; t++) begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk); #1;
                    end
                    if (!acc) break;
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 3000; cyc++) begin
                    bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
                    @(negedge clk);
                    if (!bus.out_ready) begin
                        if (!bus.in_ready) saw_block = 1;
                        if (bus.out_valid && n < exp_q.size())
                            check({tag, "_held"}, bus.out_window, exp_q[n]);
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        got_win.push_back(bus.out_window);
                        got_last.push_back(bus.out_last);
                        n++;
                    end
                    @(posedge clk); #1;
                    if (got_last.size() > 0 && got_last[got_last.size()-1]) begin
                        timeout = 0;
                        break;
                    end
                end
                bus.out_ready = 1'b1;
                done_flag = 1;
            end
        join

        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_count"}, got_win.size(), exp_q.size());
        nlast = 0;
        foreach (got_win[k]) begin
            if (k < exp_q.size())
                check($sformatf("%s_win%0d", tag, k), got_win[k], exp_q[k]);
            if (got_last[k]) nlast++;
        end
        check({tag, "_nlast"}, nlast, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic cfg_err_case(input int w, h, pad, str, input string tag);
        @(posedge clk); #1;
        img_width = DIM_W'(w); img_height = DIM_W'(h);
        padding_mode = 2'(pad); stride = 2'(str); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_err"}, cfg_err, 1);
        check({tag, "_busy"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, cfg_err, 0);
        check({tag, "_busy2"}, busy, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_window", bus.out_window, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 ramp, zero padding, stride 1
        run_frame(4, 4, 1, 1, -1, 0, "pad4");
        check("pad4_first", got_win.size() > 0 ? got_win[0] : '0, pk9(0,0,0, 0,0,1, 0,4,5));
        check("pad4_last", got_win.size() == 16 ? got_win[15] : '0, pk9(10,11,0, 14,15,0, 0,0,0));
        check("pad4_last_flag", got_last.size() == 16 ? got_last[15] : 1'b0, 1);

        // 4x4 ramp, no padding
        run_frame(4, 4, 0, 1, -1, 0, "nopad4");
        check("nopad4_first", got_win.size() > 0 ? got_win[0] : '0, pk9(0,1,2, 4,5,6, 8,9,10));
        check("nopad4_last", got_win.size() == 4 ? got_win[3] : '0, pk9(5,6,7, 9,10,11, 13,14,15));

        // backpressure: out_ready low for 20 cycles mid-frame
        run_frame(8, 8, 1, 1, 10, 20, "bp");
        check("bp_in_ready_dropped", saw_block, 1);

`ifdef WINDOW_BUF_STRIDE2_EN
        run_frame(5, 5, 0, 2, -1, 0, "s2");
        check("s2_tl0", got_win.size() == 4 ? got_win[0][DATA_W-1:0] : 16'hffff, 0);
        check("s2_tl1", got_win.size() == 4 ? got_win[1][DATA_W-1:0] : 16'hffff, 2);
        check("s2_tl2", got_win.size() == 4 ? got_win[2][DATA_W-1:0] : 16'hffff, 10);
        check("s2_tl3", got_win.size() == 4 ? got_win[3][DATA_W-1:0] : 16'hffff, 12);
`else
        cfg_err_case(5, 5, 0, 2, "s2_off");
`endif

        // reset after 7 pixels of a frame, then a clean frame
        @(posedge clk); #1;
        img_width = 8'd4; img_height = 8'd4; padding_mode = 2'b01; stride = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int sent;
            sent = 0;
            for (int t = 0; t < 100 && sent < 7; t++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DATA_W'(sent);
                @(negedge clk);
                if (bus.in_ready) sent++;
                @(posedge clk); #1;
            end
            check("mid_sent", sent, 7);
        end
        bus.in_valid = 1'b0;
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_window", bus.out_window, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(4, 4, 1, 1, -1, 0, "after_rst");
        check("after_rst_first", got_win.size() > 0 ? got_win[0] : '0, pk9(0,0,0, 0,0,1, 0,4,5));

        // configuration errors
        cfg_err_case(2, 4, 0, 1, "w2_nopad");
        cfg_err_case(0, 4, 1, 1, "w0");
        cfg_err_case(4, 4, 2, 1, "padmode2");
        cfg_err_case(4, 4, 1, 0, "stride0");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
